mbldcm_freq_ramp: RTL and testbench

Frequency ramp controller for the BLDC motor core. It sits between the host register block and the motor core's frequency-target input. On command it steps the motor frequency target from its current value toward a setpoint in bounded increments. After each increment it waits for the core to report that the new frequency has been reflected, then holds for a programmable interval. It also arbitrates the target latch between the ramp engine and direct host writes.

---
 rtl/mbldcm_freq_ramp.sv | 174 +++++++++++++++++
 tb/tb_mbldcm_freq_ramp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbldcm_freq_ramp.sv
// mbldcm_freq_ramp
// Frequency ramp controller for the BLDC motor core. On a start command it
// moves the frequency target toward a setpoint in bounded steps. After each
// step it waits for the core to reflect the new value, then holds for a
// programmable interval before taking the next step. Direct host writes take
// priority over the ramp.
//
// Ports:
//   iClock, iReset       clock, asynchronous active-high reset
//   iStart               start ramp pulse (sampled in IDLE only)
//   iAbort               abort ramp level
//   iSetpoint/iStep/iInterval  ramp parameters, captured at start
//   iHostLatch/iHostFreq direct host write strobe and value
//   iFreqReflected       core status: latched target is in effect
//   oFreqTarget          current target to the motor core (registered)
//   oLatchFreqTarget     1-cycle latch strobe (registered)
//   oBusy                ramp in progress, WAIT or HOLD (registered)
//   oDone                1-cycle ramp completion pulse (registered)
module mbldcm_freq_ramp #(
  parameter int unsigned pFreqWidth     = 32,
  parameter int unsigned pIntervalWidth = 16
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic                      iAbort,
  input  logic [pFreqWidth-1:0]     iSetpoint,
  input  logic [pFreqWidth-1:0]     iStep,
  input  logic [pIntervalWidth-1:0] iInterval,
  input  logic                      iHostLatch,
  input  logic [pFreqWidth-1:0]     iHostFreq,
  input  logic                      iFreqReflected,
  output logic [pFreqWidth-1:0]     oFreqTarget,
  output logic                      oLatchFreqTarget,
  output logic                      oBusy,
  output logic                      oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT                     rState, stateNext;
  logic [pFreqWidth-1:0]     rCurrent, currentNext;
  logic [pFreqWidth-1:0]     rSetpoint, setpointNext;
  logic [pFreqWidth-1:0]     rStep, stepNext;
  logic [pIntervalWidth-1:0] rInterval, intervalNext;
  logic [pIntervalWidth-1:0] rCounter, counterNext;
  logic                      rWaitSeen, waitSeenNext;
  logic                      rLatch, latchNext;
  logic                      rBusy, busyNext;
  logic                      rDone, doneNext;

  // Step computation: in IDLE the live inputs are used since they are being
  // captured on the same edge; otherwise the captured ramp parameters.
  logic [pFreqWidth-1:0] stepTarget, stepSize, distance, delta, nextValue;
  logic                  stepUp;

  always_comb begin
    stepTarget = (rState == IDLE) ? iSetpoint : rSetpoint;
    stepSize   = (rState == IDLE) ? iStep     : rStep;
    stepUp     = (stepTarget > rCurrent);
    distance   = stepUp ? (stepTarget - rCurrent) : (rCurrent - stepTarget);
    // Clamping to the remaining distance prevents overshoot and wrap.
    delta      = (stepSize < distance) ? stepSize : distance;
    nextValue  = stepUp ? (rCurrent + delta) : (rCurrent - delta);
  end

  // Next-state and next-output logic: host write, then abort, then FSM.
  always_comb begin
    stateNext    = rState;
    currentNext  = rCurrent;
    setpointNext = rSetpoint;
    stepNext     = rStep;
    intervalNext = rInterval;
    counterNext  = rCounter;
    waitSeenNext = rWaitSeen;
    latchNext    = 1'b0;

    if (iHostLatch) begin
      currentNext = iHostFreq;
      latchNext   = 1'b1;
      stateNext   = IDLE;
    end else if (iAbort && (rState != IDLE)) begin
      stateNext = IDLE;
    end else begin
      unique case (rState)
        IDLE: begin
          // An abort level in IDLE blocks a same-edge start.
          if (iStart && !iAbort) begin
            setpointNext = iSetpoint;
            stepNext     = iStep;
            intervalNext = iInterval;
            if ((iStep == '0) || (iSetpoint == rCurrent)) begin
              stateNext = DONE;
            end else begin
              currentNext  = nextValue;
              latchNext    = 1'b1;
              waitSeenNext = 1'b0;
              stateNext    = WAIT;
            end
          end
        end
        WAIT: begin
          // Status on the first WAIT cycle may predate the new latch.
          waitSeenNext = 1'b1;
          if (rWaitSeen && iFreqReflected) begin
            if (rCurrent == rSetpoint) begin
              stateNext = DONE;
            end else begin
              counterNext = rInterval;
              stateNext   = HOLD;
            end
          end
        end
        HOLD: begin
          if (rCounter == '0) begin
            currentNext  = nextValue;
            latchNext    = 1'b1;
            waitSeenNext = 1'b0;
            stateNext    = WAIT;
          end else begin
            counterNext = rCounter - pIntervalWidth'(1);
          end
        end
        DONE: begin
          stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end

    busyNext = (stateNext == WAIT) || (stateNext == HOLD);
    doneNext = (stateNext == DONE);
  end

  // State and output registers.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rState    <= IDLE;
      rCurrent  <= '0;
      rSetpoint <= '0;
      rStep     <= '0;
      rInterval <= '0;
      rCounter  <= '0;
      rWaitSeen <= 1'b0;
      rLatch    <= 1'b0;
      rBusy     <= 1'b0;
      rDone     <= 1'b0;
    end else begin
      rState    <= stateNext;
      rCurrent  <= currentNext;
      rSetpoint <= setpointNext;
      rStep     <= stepNext;
      rInterval <= intervalNext;
      rCounter  <= counterNext;
      rWaitSeen <= waitSeenNext;
      rLatch    <= latchNext;
      rBusy     <= busyNext;
      rDone     <= doneNext;
    end
  end

  assign oFreqTarget      = rCurrent;
  assign oLatchFreqTarget = rLatch;
  assign oBusy            = rBusy;
  assign oDone            = rDone;

endmodule

// File: tb/tb_mbldcm_freq_ramp.sv
// tb_mbldcm_freq_ramp
// Self-checking bench for mbldcm_freq_ramp. Expected latch values are queued
// when stimulus is applied and popped when the DUT raises its latch strobe.
// A small core model raises iFreqReflected one cycle after each latch is seen.
module tb_mbldcm_freq_ramp;

  logic        iClock;
  logic        iReset;
  logic        iStart;
  logic        iAbort;
  logic [31:0] iSetpoint;
  logic [31:0] iStep;
  logic [15:0] iInterval;
  logic        iHostLatch;
  logic [31:0] iHostFreq;
  logic        iFreqReflected;
  logic [31:0] oFreqTarget;
  logic        oLatchFreqTarget;
  logic        oBusy;
  logic        oDone;

  mbldcm_freq_ramp #(.pFreqWidth(32), .pIntervalWidth(16)) dut (
    .iClock(iClock),
    .iReset(iReset),
    .iStart(iStart),
    .iAbort(iAbort),
    .iSetpoint(iSetpoint),
    .iStep(iStep),
    .iInterval(iInterval),
    .iHostLatch(iHostLatch),
    .iHostFreq(iHostFreq),
    .iFreqReflected(iFreqReflected),
    .oFreqTarget(oFreqTarget),
    .oLatchFreqTarget(oLatchFreqTarget),
    .oBusy(oBusy),
    .oDone(oDone)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expQ[$];
  logic [31:0] expTarget   = '0;
  int          latchEdges[$];
  int          cyc         = 0;
  int          doneCount   = 0;
  int          doneEdge    = 0;
  logic        doneBusy    = 1'b0;
  bit          reflEnable  = 1'b1;
  bit          reflAlways  = 1'b0;
  int          reflTimer   = 0;
  int          startEdge   = 0;
  int          n0          = 0;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock: sample outputs #1 after the edge, then run the core model.
  task automatic stepCycle();
    logic [31:0] e;
    bit          seenLatch;
    @(posedge iClock);
    cyc++;
    #1;
    seenLatch = 1'b0;
    if (!iReset) begin
      if (oLatchFreqTarget) begin
        seenLatch = 1'b1;
        latchEdges.push_back(cyc);
        if (expQ.size() == 0) begin
          checkVal("latch_unexpected", 64'(oLatchFreqTarget), 64'(0));
        end else begin
          e = expQ.pop_front();
          checkVal("latch_value", 64'(oFreqTarget), 64'(e));
          expTarget = e;
        end
      end else begin
        checkVal("target_hold", 64'(oFreqTarget), 64'(expTarget));
      end
      if (oDone) begin
        doneCount++;
        doneEdge = cyc;
        doneBusy = oBusy;
      end
    end
    iFreqReflected = reflAlways;
    if (!reflAlways && reflEnable) begin
      if (seenLatch) begin
        reflTimer = 1;
      end else if (reflTimer > 0) begin
        reflTimer--;
        if (reflTimer == 0) iFreqReflected = 1'b1;
      end
    end
  endtask

  task automatic startRamp(input logic [31:0] sp, input logic [31:0] st, input logic [15:0] iv);
    iSetpoint = sp;
    iStep     = st;
    iInterval = iv;
    iStart    = 1'b1;
    stepCycle();
    iStart    = 1'b0;
    startEdge = cyc;
  endtask

  task automatic waitDone(input int target, input int bound);
    int n;
    n = 0;
    while (doneCount < target && n < bound) begin
      stepCycle();
      n++;
    end
    if (doneCount < target) checkVal("done_timeout", 64'(doneCount), 64'(target));
  endtask

  task automatic runCycles(input int k);
    for (int i = 0; i < k; i++) stepCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1; iStart = 1'b0; iAbort = 1'b0;
    iSetpoint = '0; iStep = '0; iInterval = '0;
    iHostLatch = 1'b0; iHostFreq = '0; iFreqReflected = 1'b0;

    // Reset state
    #2;
    checkVal("rst_target", 64'(oFreqTarget), 64'(0));
    checkVal("rst_latch", 64'(oLatchFreqTarget), 64'(0));
    checkVal("rst_busy", 64'(oBusy), 64'(0));
    checkVal("rst_done", 64'(oDone), 64'(0));
    runCycles(2);
    iReset = 1'b0;
    runCycles(2);

    // Up ramp 0 -> 100, step 40, interval 3
    latchEdges.delete();
    doneCount = 0;
    expQ.push_back(32'd40); expQ.push_back(32'd80); expQ.push_back(32'd100);
    startRamp(32'd100, 32'd40, 16'd3);
    checkVal("up_busy_first", 64'(oBusy), 64'(1));
    waitDone(1, 100);
    checkVal("up_latch_count", 64'(latchEdges.size()), 64'(3));
    if (latchEdges.size() == 3) begin
      checkVal("up_first_latch_edge", 64'(latchEdges[0]), 64'(startEdge));
      checkVal("up_spacing1", 64'(latchEdges[1] - latchEdges[0]), 64'(2 + 3 + 1));
      checkVal("up_spacing2", 64'(latchEdges[2] - latchEdges[1]), 64'(2 + 3 + 1));
      checkVal("up_done_edge", 64'(doneEdge), 64'(latchEdges[2] + 2));
    end
    checkVal("up_busy_at_done", 64'(doneBusy), 64'(0));
    stepCycle();
    checkVal("up_done_pulse_width", 64'(oDone), 64'(0));
    runCycles(5);
    checkVal("up_done_count", 64'(doneCount), 64'(1));
    checkVal("up_final_busy", 64'(oBusy), 64'(0));

    // Down ramp 100 -> 5, step 60 clamped on the last step
    latchEdges.delete();
    doneCount = 0;
    expQ.push_back(32'd40); expQ.push_back(32'd5);
    startRamp(32'd5, 32'd60, 16'd0);
    waitDone(1, 100);
    checkVal("down_latch_count", 64'(latchEdges.size()), 64'(2));
    if (latchEdges.size() == 2)
      checkVal("down_spacing", 64'(latchEdges[1] - latchEdges[0]), 64'(2 + 0 + 1));
    runCycles(3);
    checkVal("down_final_target", 64'(oFreqTarget), 64'(5));
    checkVal("down_done_count", 64'(doneCount), 64'(1));

    // Degenerate start: step 0
    doneCount = 0;
    latchEdges.delete();
    startRamp(32'd200, 32'd0, 16'd2);
    checkVal("deg0_done", 64'(oDone), 64'(1));
    checkVal("deg0_busy", 64'(oBusy), 64'(0));
    stepCycle();
    checkVal("deg0_done_clear", 64'(oDone), 64'(0));
    checkVal("deg0_busy2", 64'(oBusy), 64'(0));
    // Degenerate start: setpoint equals current
    startRamp(32'd5, 32'd10, 16'd0);
    checkVal("degeq_done", 64'(oDone), 64'(1));
    checkVal("degeq_busy", 64'(oBusy), 64'(0));
    runCycles(3);
    checkVal("deg_done_count", 64'(doneCount), 64'(2));
    checkVal("deg_no_latch", 64'(latchEdges.size()), 64'(0));

    // Abort in HOLD
    doneCount = 0;
    expQ.push_back(32'd105);
    startRamp(32'd1000, 32'd100, 16'd10);
    runCycles(4);
    iAbort = 1'b1;
    stepCycle();
    iAbort = 1'b0;
    checkVal("abort_busy", 64'(oBusy), 64'(0));
    runCycles(20);
    checkVal("abort_target", 64'(oFreqTarget), 64'(105));
    checkVal("abort_no_done", 64'(doneCount), 64'(0));
    // Start blocked by abort in IDLE
    iAbort = 1'b1;
    startRamp(32'd300, 32'd10, 16'd0);
    iAbort = 1'b0;
    checkVal("abort_idle_busy", 64'(oBusy), 64'(0));
    checkVal("abort_idle_done", 64'(oDone), 64'(0));
    runCycles(5);
    checkVal("abort_idle_no_done", 64'(doneCount), 64'(0));

    // Host override while a ramp latch is due
    doneCount = 0;
    latchEdges.delete();
    expQ.push_back(32'd205);
    startRamp(32'd1000, 32'd100, 16'd0);
    runCycles(2);
    iHostLatch = 1'b1;
    iHostFreq  = 32'd777;
    expQ.push_back(32'd777);
    stepCycle();
    iHostLatch = 1'b0;
    checkVal("host_busy", 64'(oBusy), 64'(0));
    checkVal("host_latch_edge", 64'(latchEdges[latchEdges.size()-1]), 64'(startEdge + 3));
    runCycles(20);
    checkVal("host_latch_count", 64'(latchEdges.size()), 64'(2));
    checkVal("host_no_done", 64'(doneCount), 64'(0));

    // Back-to-back host writes
    latchEdges.delete();
    iHostLatch = 1'b1;
    iHostFreq  = 32'd10;
    expQ.push_back(32'd10);
    stepCycle();
    iHostFreq  = 32'd20;
    expQ.push_back(32'd20);
    stepCycle();
    iHostLatch = 1'b0;
    runCycles(3);
    checkVal("host_b2b_count", 64'(latchEdges.size()), 64'(2));
    if (latchEdges.size() == 2)
      checkVal("host_b2b_spacing", 64'(latchEdges[1] - latchEdges[0]), 64'(1));

    // Stale status: reflection held high, spacing still bounded
    reflAlways = 1'b1;
    doneCount = 0;
    latchEdges.delete();
    expQ.push_back(32'd23); expQ.push_back(32'd26); expQ.push_back(32'd29);
    startRamp(32'd29, 32'd3, 16'd0);
    waitDone(1, 100);
    checkVal("stale_latch_count", 64'(latchEdges.size()), 64'(3));
    if (latchEdges.size() == 3) begin
      checkVal("stale_spacing1", 64'(latchEdges[1] - latchEdges[0]), 64'(3));
      checkVal("stale_spacing2", 64'(latchEdges[2] - latchEdges[1]), 64'(3));
      checkVal("stale_done_edge", 64'(doneEdge), 64'(latchEdges[2] + 2));
    end
    reflAlways = 1'b0;
    runCycles(3);

    // Asynchronous reset mid-WAIT
    reflEnable = 1'b0;
    doneCount = 0;
    expQ.push_back(32'd79);
    startRamp(32'd1000, 32'd50, 16'd0);
    runCycles(2);
    checkVal("rstw_busy_before", 64'(oBusy), 64'(1));
    #2;
    iReset = 1'b1;
    #1;
    checkVal("rstw_target", 64'(oFreqTarget), 64'(0));
    checkVal("rstw_latch", 64'(oLatchFreqTarget), 64'(0));
    checkVal("rstw_busy", 64'(oBusy), 64'(0));
    checkVal("rstw_done", 64'(oDone), 64'(0));
    expQ.delete();
    expTarget = '0;
    runCycles(2);
    iReset = 1'b0;
    reflEnable = 1'b1;
    n0 = latchEdges.size();
    runCycles(10);
    checkVal("rstw_no_latch", 64'(latchEdges.size()), 64'(n0));
    checkVal("rstw_no_done", 64'(doneCount), 64'(0));
    checkVal("rstw_busy_after", 64'(oBusy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
